pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
Parametrised successor to the single-cycle MIPS control decoder. It decodes the ID-stage opcode into a control word and carries that word through the ID/EX, EX/MEM and MEM/WB control registers. It also carries destination, rs and rt register numbers, detects load-use hazards, generates forwarding selects and applies flushes for taken branches and jumps. It sits beside the datapath of the 5-stage pipelined processor and drives every stage's control signals.

Parameters:
OPCODE_W, 6, opcode width in bits.
REG_ADDR_W, 5, register-number width in bits.
ALUOP_W, 2, ALUOp width in bits; values are zero-extended from the 2-bit codes below.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all stage registers
opcode_id  in  OPCODE_W  instruction opcode in ID
rs_id, rt_id, rd_id  in  REG_ADDR_W  register fields in ID
branch_taken_ex  in  1  EX-stage beq resolved taken
hold  in  1  global freeze (memory wait)
ex_reg_dst, ex_alu_src  out  1  EX-stage control
ex_alu_op  out  ALUOP_W  EX-stage ALUOp
mem_read, mem_write  out  1  MEM-stage control
wb_mem_to_reg, wb_reg_write  out  1  WB-stage control
wb_dst  out  REG_ADDR_W  WB destination register
forward_a, forward_b  out  2  EX operand select: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB
pc_write, ifid_write  out  1  low = stall fetch and decode
ifid_flush  out  1  clear IF/ID
jump_id  out  1  ID-stage jump select
illegal_id  out  1  ID opcode not in the decode table

Behaviour:
- Decode (combinational, ID). Any opcode not listed below sets all control bits to 0 and illegal_id = 1.
  - 000000 R-type: RegDst, RegWrite; ALUOp = 10.
  - 001000 addi: ALUSrc, RegWrite; ALUOp = 00.
  - 100011 lw: ALUSrc, MemRead, MemtoReg, RegWrite; ALUOp = 00.
  - 101011 sw: ALUSrc, MemWrite; ALUOp = 00.
  - 000100 beq: Branch; ALUOp = 01.
  - 000010 j: Jump.
- Destination: selected in ID as RegDst ? rd_id : rt_id. It travels with the control word.
- Stage registers: ID/EX holds the full control word plus rs, rt and destination. EX/MEM holds MEM and WB fields plus destination. MEM/WB holds WB fields plus destination.
- Latency: an instruction's EX controls appear 1 cycle after it is in ID, MEM controls after 2 cycles, WB controls after 3 cycles.
- Reset: asynchronous. All stage registers clear to 0, including destinations. All outputs are therefore 0, except pc_write = 1 and ifid_write = 1, which are combinational.
- Load-use stall:
  - Condition: ID/EX MemRead = 1 and ID/EX rt ≠ 0 and (ID/EX rt == rs_id or ID/EX rt == rt_id).
  - Response: pc_write = 0 and ifid_write = 0, and a bubble (all-zero control word, destination 0) loads into ID/EX.
  - The stall lasts exactly 1 cycle.
- Flush on branch: branch_taken_ex = 1 asserts ifid_flush, loads a bubble into ID/EX, and forces pc_write = 1.
- Flush on jump: decoded Jump in ID asserts ifid_flush, costing one bubble in IF/ID. jump_id = decoded Jump.
- Priority: reset > hold > branch flush > load-use stall > normal advance.
  - A branch flush overrides a coincident stall.
  - hold = 1 freezes all three stage registers; pc_write = 0, ifid_write = 0, ifid_flush = 0.
- Forwarding A (uses ID/EX rs):
  - 10 if EX/MEM RegWrite and EX/MEM dst ≠ 0 and EX/MEM dst == rs.
  - Otherwise 01 if MEM/WB RegWrite and MEM/WB dst ≠ 0 and MEM/WB dst == rs.
  - Otherwise 00.
- Forwarding B: same rule as A, using ID/EX rt.
- Forwarding priority: EX/MEM beats MEM/WB when both match.
- Register 0 never forwards and never causes a stall.

Test Plan:
- Reset asserted mid-stream with lw in the pipe -> all control outputs 0 immediately (asynchronous); pc_write = 1; after release, first add at ID shows ex_reg_dst = 1 one cycle later.
- Sequence 000000, 001000, 100011, 101011, 000100, 000010 (rs/rt chosen with no dependencies) -> per-stage outputs match the decode table at +1/+2/+3 cycles; j gives jump_id = 1 and ifid_flush = 1 in its ID cycle; opcode 111111 gives illegal_id = 1 and a zero control word.
- lw $8 followed by add using rs = 8 -> one cycle with pc_write = 0 and ifid_write = 0 and a bubble in EX; the next cycle forward_a = 01.
- add $9 followed by sub using rs = 9 and rt = 9 -> forward_a = forward_b = 10; the same with dst = 0 -> both 00.
- branch_taken_ex = 1 in the same cycle as a load-use condition -> ifid_flush = 1, pc_write = 1, bubble in ID/EX, no stall.
- hold = 1 for 3 cycles with lw in EX/MEM -> mem_read stays 1, stage registers unchanged, pc_write = 0; pipeline resumes correctly when hold drops.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Decodes the ID opcode and carries the control word through ID/EX, EX/MEM and MEM/WB.
// Adds load-use stall detection, forwarding selects and branch/jump flushes.
// The priority order is reset, then hold, then branch flush, then load-use stall, then normal advance.
module pipelined_control_unit #(
  parameter int OPCODE_W   = 6,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   opcode_id,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  branch_taken_ex,
  input  logic                  hold,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_mem_to_reg,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  jump_id,
  output logic                  illegal_id
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(2'b10);

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Decoded ID-stage control word
  logic                  dec_reg_dst;
  logic                  dec_alu_src;
  logic [ALUOP_W-1:0]    dec_alu_op;
  logic                  dec_mem_read;
  logic                  dec_mem_write;
  logic                  dec_mem_to_reg;
  logic                  dec_reg_write;
  logic                  dec_jump;
  logic                  dec_illegal;
  logic [REG_ADDR_W-1:0] dst_id;

  // ID/EX register. The branch decision itself is resolved by the datapath
  // and arrives on branch_taken_ex, so only the fields that drive
  // EX, MEM or WB controls are carried here.
  logic                  idex_reg_dst;
  logic                  idex_alu_src;
  logic [ALUOP_W-1:0]    idex_alu_op;
  logic                  idex_mem_read;
  logic                  idex_mem_write;
  logic                  idex_mem_to_reg;
  logic                  idex_reg_write;
  logic [REG_ADDR_W-1:0] idex_rs;
  logic [REG_ADDR_W-1:0] idex_rt;
  logic [REG_ADDR_W-1:0] idex_dst;

  // EX/MEM register
  logic                  exmem_mem_read;
  logic                  exmem_mem_write;
  logic                  exmem_mem_to_reg;
  logic                  exmem_reg_write;
  logic [REG_ADDR_W-1:0] exmem_dst;

  // MEM/WB register
  logic                  memwb_mem_to_reg;
  logic                  memwb_reg_write;
  logic [REG_ADDR_W-1:0] memwb_dst;

  logic load_use;
  logic insert_bubble;

  // Opcode decode table; unknown opcodes yield an all-zero word and flag illegal
  always_comb begin
    dec_reg_dst    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_op     = ALU_ADD;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_reg_write  = 1'b0;
    dec_jump       = 1'b0;
    dec_illegal    = 1'b0;
    case (opcode_id)
      OP_RTYPE: begin
        dec_reg_dst   = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_op    = ALU_FUNC;
      end
      OP_ADDI: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_LW: begin
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_reg_write  = 1'b1;
      end
      OP_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_alu_op = ALU_SUB;
      end
      OP_J: begin
        dec_jump = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dst_id     = dec_reg_dst ? rd_id : rt_id;
  assign jump_id    = dec_jump;
  assign illegal_id = dec_illegal;

  // Load-use hazard: a load in EX whose target is read by the instruction in ID.
  // Register 0 is hardwired so it never creates a dependency.
  assign load_use = idex_mem_read && (idex_rt != '0) &&
                    ((idex_rt == rs_id) || (idex_rt == rt_id));

  // A taken branch squashes the ID instruction, which also cancels any stall it caused
  assign insert_bubble = branch_taken_ex || load_use;

  // Fetch/decode enables and IF/ID flush, following the priority order
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    if (reset) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
    end else if (hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
    end else if (branch_taken_ex) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
    end else begin
      ifid_flush = dec_jump;
    end
  end

  // ID/EX: load decoded word, or a bubble on flush/stall; frozen while hold is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_reg_dst    <= 1'b0;
      idex_alu_src    <= 1'b0;
      idex_alu_op     <= '0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_mem_to_reg <= 1'b0;
      idex_reg_write  <= 1'b0;
      idex_rs         <= '0;
      idex_rt         <= '0;
      idex_dst        <= '0;
    end else if (!hold) begin
      if (insert_bubble) begin
        idex_reg_dst    <= 1'b0;
        idex_alu_src    <= 1'b0;
        idex_alu_op     <= '0;
        idex_mem_read   <= 1'b0;
        idex_mem_write  <= 1'b0;
        idex_mem_to_reg <= 1'b0;
        idex_reg_write  <= 1'b0;
        idex_rs         <= '0;
        idex_rt         <= '0;
        idex_dst        <= '0;
      end else begin
        idex_reg_dst    <= dec_reg_dst;
        idex_alu_src    <= dec_alu_src;
        idex_alu_op     <= dec_alu_op;
        idex_mem_read   <= dec_mem_read;
        idex_mem_write  <= dec_mem_write;
        idex_mem_to_reg <= dec_mem_to_reg;
        idex_reg_write  <= dec_reg_write;
        idex_rs         <= rs_id;
        idex_rt         <= rt_id;
        idex_dst        <= dst_id;
      end
    end
  end

  // EX/MEM: MEM and WB fields advance from ID/EX unless held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_dst        <= '0;
    end else if (!hold) begin
      exmem_mem_read   <= idex_mem_read;
      exmem_mem_write  <= idex_mem_write;
      exmem_mem_to_reg <= idex_mem_to_reg;
      exmem_reg_write  <= idex_reg_write;
      exmem_dst        <= idex_dst;
    end
  end

  // MEM/WB: WB fields advance from EX/MEM unless held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memwb_mem_to_reg <= 1'b0;
      memwb_reg_write  <= 1'b0;
      memwb_dst        <= '0;
    end else if (!hold) begin
      memwb_mem_to_reg <= exmem_mem_to_reg;
      memwb_reg_write  <= exmem_reg_write;
      memwb_dst        <= exmem_dst;
    end
  end

  // Forwarding selects; the younger EX/MEM result wins over MEM/WB, and register 0 never forwards
  always_comb begin
    forward_a = FWD_REG;
    forward_b = FWD_REG;
    if (exmem_reg_write && (exmem_dst != '0) && (exmem_dst == idex_rs)) begin
      forward_a = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_dst != '0) && (memwb_dst == idex_rs)) begin
      forward_a = FWD_MEMWB;
    end
    if (exmem_reg_write && (exmem_dst != '0) && (exmem_dst == idex_rt)) begin
      forward_b = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_dst != '0) && (memwb_dst == idex_rt)) begin
      forward_b = FWD_MEMWB;
    end
  end

  assign ex_reg_dst    = idex_reg_dst;
  assign ex_alu_src    = idex_alu_src;
  assign ex_alu_op     = idex_alu_op;
  assign mem_read      = exmem_mem_read;
  assign mem_write     = exmem_mem_write;
  assign wb_mem_to_reg = memwb_mem_to_reg;
  assign wb_reg_write  = memwb_reg_write;
  assign wb_dst        = memwb_dst;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed testbench for pipelined_control_unit.
// Inputs change 1 time unit after the rising edge, and outputs are sampled 1 to 2 time units later.
// Each scenario task does its own comparisons, and the summary line reports the totals.
module tb_pipelined_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] opcode_id;
  logic [4:0] rs_id, rt_id, rd_id;
  logic       branch_taken_ex;
  logic       hold;
  logic       ex_reg_dst, ex_alu_src;
  logic [1:0] ex_alu_op;
  logic       mem_read, mem_write;
  logic       wb_mem_to_reg, wb_reg_write;
  logic [4:0] wb_dst;
  logic [1:0] forward_a, forward_b;
  logic       pc_write, ifid_write, ifid_flush, jump_id, illegal_id;

  int checks = 0;
  int errors = 0;

  pipelined_control_unit #(.OPCODE_W(6), .REG_ADDR_W(5), .ALUOP_W(2)) dut (
    .clk(clk), .reset(reset), .opcode_id(opcode_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .branch_taken_ex(branch_taken_ex), .hold(hold),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .mem_read(mem_read), .mem_write(mem_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
    .forward_a(forward_a), .forward_b(forward_b),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .jump_id(jump_id), .illegal_id(illegal_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    opcode_id = op;
    rs_id     = rs;
    rt_id     = rt;
    rd_id     = rd;
  endtask

  // Fill the pipe with illegal opcodes (zero control word, destination 0)
  task automatic drain();
    set_id(6'b111111, 5'd0, 5'd0, 5'd0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({ex_reg_dst, ex_alu_src, ex_alu_op} !== 4'b0000) begin errors++; $display("FAIL rst_ex got %b exp 0000", {ex_reg_dst, ex_alu_src, ex_alu_op}); end
    checks++; if ({mem_read, mem_write, wb_mem_to_reg, wb_reg_write} !== 4'b0000) begin errors++; $display("FAIL rst_mem_wb got %b exp 0000", {mem_read, mem_write, wb_mem_to_reg, wb_reg_write}); end
    checks++; if (wb_dst !== 5'd0) begin errors++; $display("FAIL rst_wb_dst got %0d exp 0", wb_dst); end
    checks++; if ({forward_a, forward_b} !== 4'b0000) begin errors++; $display("FAIL rst_fwd got %b exp 0000", {forward_a, forward_b}); end
    checks++; if ({pc_write, ifid_write, ifid_flush} !== 3'b110) begin errors++; $display("FAIL rst_enables got %b exp 110", {pc_write, ifid_write, ifid_flush}); end
    step();
    reset = 1'b0;
    set_id(6'b100011, 5'd1, 5'd8, 5'd0);          // lw $8
    step();
    set_id(6'b000000, 5'd2, 5'd3, 5'd4);          // add $4
    step();
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL pre_rst_mem_read got %b exp 1", mem_read); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({mem_read, ex_reg_dst, wb_reg_write, wb_mem_to_reg} !== 4'b0000) begin errors++; $display("FAIL async_rst_clear got %b exp 0000", {mem_read, ex_reg_dst, wb_reg_write, wb_mem_to_reg}); end
    checks++; if ({pc_write, ifid_write} !== 2'b11) begin errors++; $display("FAIL async_rst_pc got %b exp 11", {pc_write, ifid_write}); end
    #1 reset = 1'b0;
    set_id(6'b000000, 5'd2, 5'd3, 5'd4);
    step();
    checks++; if ({ex_reg_dst, ex_alu_op} !== 3'b110) begin errors++; $display("FAIL post_rst_add got %b exp 110", {ex_reg_dst, ex_alu_op}); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL post_rst_mem_read got %b exp 0", mem_read); end
  endtask

  task automatic test_decode();
    logic [5:0] ops   [7] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b111111};
    logic [3:0] e_ex  [7] = '{4'b1010, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0000, 4'b0000};
    logic [1:0] e_mem [7] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [1:0] e_wb  [7] = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [4:0] e_dst [7] = '{5'd30, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26};
    drain();
    for (int k = 0; k < 10; k++) begin
      if (k < 7) set_id(ops[k], 5'(10 + k), 5'(20 + k), 5'(30 + k));
      else       set_id(6'b111111, 5'd0, 5'd0, 5'd0);
      #1;
      if (k < 7) begin
        checks++; if (jump_id !== (k == 5)) begin errors++; $display("FAIL dec_jump[%0d] got %b exp %b", k, jump_id, (k == 5)); end
        checks++; if (illegal_id !== (k == 6)) begin errors++; $display("FAIL dec_illegal[%0d] got %b exp %b", k, illegal_id, (k == 6)); end
        checks++; if ({pc_write, ifid_flush} !== {1'b1, (k == 5)}) begin errors++; $display("FAIL dec_pc_flush[%0d] got %b exp %b", k, {pc_write, ifid_flush}, {1'b1, (k == 5)}); end
      end
      step();
      if (k < 7) begin
        checks++; if ({ex_reg_dst, ex_alu_src, ex_alu_op} !== e_ex[k]) begin errors++; $display("FAIL dec_ex[%0d] got %b exp %b", k, {ex_reg_dst, ex_alu_src, ex_alu_op}, e_ex[k]); end
      end
      if (k >= 1 && k <= 7) begin
        checks++; if ({mem_read, mem_write} !== e_mem[k-1]) begin errors++; $display("FAIL dec_mem[%0d] got %b exp %b", k - 1, {mem_read, mem_write}, e_mem[k-1]); end
      end
      if (k >= 2 && k <= 8) begin
        checks++; if ({wb_mem_to_reg, wb_reg_write} !== e_wb[k-2]) begin errors++; $display("FAIL dec_wb[%0d] got %b exp %b", k - 2, {wb_mem_to_reg, wb_reg_write}, e_wb[k-2]); end
        checks++; if (wb_dst !== e_dst[k-2]) begin errors++; $display("FAIL dec_wb_dst[%0d] got %0d exp %0d", k - 2, wb_dst, e_dst[k-2]); end
      end
    end
  endtask

  task automatic test_load_use();
    drain();
    set_id(6'b100011, 5'd1, 5'd8, 5'd0);          // lw $8
    step();
    set_id(6'b000000, 5'd8, 5'd3, 5'd9);          // add $9, $8, $3
    #1;
    checks++; if ({pc_write, ifid_write, ifid_flush} !== 3'b000) begin errors++; $display("FAIL lu_stall got %b exp 000", {pc_write, ifid_write, ifid_flush}); end
    step();
    checks++; if ({ex_reg_dst, ex_alu_src, ex_alu_op} !== 4'b0000) begin errors++; $display("FAIL lu_bubble got %b exp 0000", {ex_reg_dst, ex_alu_src, ex_alu_op}); end
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL lu_mem_read got %b exp 1", mem_read); end
    checks++; if ({pc_write, ifid_write} !== 2'b11) begin errors++; $display("FAIL lu_one_cycle got %b exp 11", {pc_write, ifid_write}); end
    step();
    checks++; if ({forward_a, forward_b} !== 4'b0100) begin errors++; $display("FAIL lu_fwd got %b exp 0100", {forward_a, forward_b}); end
    checks++; if (ex_reg_dst !== 1'b1) begin errors++; $display("FAIL lu_add_ex got %b exp 1", ex_reg_dst); end
    drain();
    set_id(6'b100011, 5'd1, 5'd0, 5'd0);          // lw $0
    step();
    set_id(6'b000000, 5'd0, 5'd0, 5'd5);
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_reg0_no_stall got %b exp 1", pc_write); end
  endtask

  task automatic test_forward();
    drain();
    set_id(6'b000000, 5'd1, 5'd2, 5'd9);          // add $9
    step();
    set_id(6'b000000, 5'd9, 5'd9, 5'd10);         // sub $10, $9, $9
    step();
    checks++; if ({forward_a, forward_b} !== 4'b1010) begin errors++; $display("FAIL fwd_exmem got %b exp 1010", {forward_a, forward_b}); end
    drain();
    set_id(6'b000000, 5'd1, 5'd2, 5'd9);
    step();
    set_id(6'b000000, 5'd1, 5'd2, 5'd9);
    step();
    set_id(6'b000000, 5'd9, 5'd5, 5'd11);
    step();
    checks++; if ({forward_a, forward_b} !== 4'b1000) begin errors++; $display("FAIL fwd_priority got %b exp 1000", {forward_a, forward_b}); end
    drain();
    set_id(6'b000000, 5'd1, 5'd2, 5'd0);          // add $0
    step();
    set_id(6'b000000, 5'd0, 5'd0, 5'd10);
    step();
    checks++; if ({forward_a, forward_b} !== 4'b0000) begin errors++; $display("FAIL fwd_reg0 got %b exp 0000", {forward_a, forward_b}); end
  endtask

  task automatic test_branch_flush();
    drain();
    set_id(6'b100011, 5'd1, 5'd8, 5'd0);          // lw $8
    step();
    set_id(6'b000000, 5'd8, 5'd0, 5'd3);          // dependent add
    branch_taken_ex = 1'b1;
    #1;
    checks++; if ({pc_write, ifid_write, ifid_flush} !== 3'b111) begin errors++; $display("FAIL br_enables got %b exp 111", {pc_write, ifid_write, ifid_flush}); end
    step();
    branch_taken_ex = 1'b0;
    set_id(6'b111111, 5'd0, 5'd0, 5'd0);
    #1;
    checks++; if ({ex_reg_dst, ex_alu_src, ex_alu_op} !== 4'b0000) begin errors++; $display("FAIL br_bubble got %b exp 0000", {ex_reg_dst, ex_alu_src, ex_alu_op}); end
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL br_lw_advances got %b exp 1", mem_read); end
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL br_no_stall got %b exp 1", pc_write); end
  endtask

  task automatic test_hold();
    drain();
    set_id(6'b100011, 5'd1, 5'd8, 5'd0);          // lw $8
    step();
    set_id(6'b001000, 5'd2, 5'd3, 5'd0);          // addi $3
    step();
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) set_id(6'b000010, 5'd0, 5'd0, 5'd0);
      else        set_id(6'b000000, 5'd4, 5'd5, 5'd6);
      #1;
      checks++; if ({pc_write, ifid_write, ifid_flush} !== 3'b000) begin errors++; $display("FAIL hold_enables[%0d] got %b exp 000", c, {pc_write, ifid_write, ifid_flush}); end
      checks++; if ({mem_read, ex_alu_src, ex_reg_dst} !== 3'b110) begin errors++; $display("FAIL hold_frozen[%0d] got %b exp 110", c, {mem_read, ex_alu_src, ex_reg_dst}); end
      step();
    end
    hold = 1'b0;
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL hold_release_pc got %b exp 1", pc_write); end
    step();
    checks++; if ({ex_reg_dst, mem_read} !== 2'b10) begin errors++; $display("FAIL hold_resume got %b exp 10", {ex_reg_dst, mem_read}); end
    checks++; if ({wb_mem_to_reg, wb_reg_write, wb_dst} !== {2'b11, 5'd8}) begin errors++; $display("FAIL hold_resume_wb got %b exp %b", {wb_mem_to_reg, wb_reg_write, wb_dst}, {2'b11, 5'd8}); end
  endtask

  initial begin
    reset = 1'b1;
    hold = 1'b0;
    branch_taken_ex = 1'b0;
    set_id(6'b000000, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_decode();
    test_load_use();
    test_forward();
    test_branch_flush();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
